// File: rtl/pcie_lane_deskew.sv
// pcie_lane_deskew
// Multi-lane receive deskew. Each lane passes through a MAX_SKEW-deep word
// history. The output of a lane is the history tap selected by its
// lane_delay, registered. The skew between lanes is measured from the arrival
// of COM (K28.5 in symbol 0) on each enabled lane. Later lanes get smaller
// delays, so all enabled lanes present COM in the same output word. Once
// locked, every output word containing COM is checked for alignment.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   rx_valid                  word strobe; all lanes advance together
//   rx_data/charisk/err       per-lane input word (16b data, 2b K, 2b err)
//   lane_en                   lanes taking part in measurement/checking
//   relock                    request a fresh skew measurement
//   out_data/charisk/err      deskewed per-lane words
//   out_valid                 rx_valid delayed one clock
//   locked                    skew measured and being verified
//   skew_err                  one-clock pulse: measurement timeout or misalignment
//   lane_delay                applied delay per lane, in words
module pcie_lane_deskew #(
  parameter int LANES    = 4,
  parameter int MAX_SKEW = 8,
  localparam int DW      = $clog2(MAX_SKEW)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_valid,
  input  logic [16*LANES-1:0]   rx_data,
  input  logic [2*LANES-1:0]    rx_charisk,
  input  logic [2*LANES-1:0]    rx_err,
  input  logic [LANES-1:0]      lane_en,
  input  logic                  relock,
  output logic [16*LANES-1:0]   out_data,
  output logic [2*LANES-1:0]    out_charisk,
  output logic [2*LANES-1:0]    out_err,
  output logic                  out_valid,
  output logic                  locked,
  output logic                  skew_err,
  output logic [DW*LANES-1:0]   lane_delay
);

  // Lane word packing: {err[1:0], charisk[1:0], data[15:0]}
  localparam int WW = 20;
  typedef logic [WW-1:0] word_t;
  typedef enum logic [1:0] {HUNT, MEASURE, LOCKED} state_t;

  word_t cur_word [LANES];
  word_t tap_word [LANES];
  word_t out_word [LANES];
  // hist[i][k] is the word that lane i presented k+1 valid words ago.
  word_t hist     [LANES][MAX_SKEW-1];

  logic [LANES-1:0] com_in;
  logic [LANES-1:0] com_out;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign cur_word[gi] = {rx_err[2*gi +: 2], rx_charisk[2*gi +: 2], rx_data[16*gi +: 16]};
      assign com_in[gi]   = rx_charisk[2*gi] && (rx_data[16*gi +: 8] == 8'hBC);
      assign com_out[gi]  = out_word[gi][16] && (out_word[gi][7:0] == 8'hBC);
      assign out_data[16*gi +: 16]  = out_word[gi][15:0];
      assign out_charisk[2*gi +: 2] = out_word[gi][17:16];
      assign out_err[2*gi +: 2]     = out_word[gi][19:18];
    end
  endgenerate

  // Tap 0 is the live input word; tap k is the word k valid words ago.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      tap_word[i] = cur_word[i];
      for (int k = 1; k < MAX_SKEW; k++) begin
        if (lane_delay[i*DW +: DW] == DW'(k)) tap_word[i] = hist[i][k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        out_word[i] <= '0;
        for (int k = 0; k < MAX_SKEW-1; k++) hist[i][k] <= '0;
      end
    end else begin
      out_valid <= rx_valid;
      if (rx_valid) begin
        for (int i = 0; i < LANES; i++) begin
          out_word[i] <= tap_word[i];
          hist[i][0]  <= cur_word[i];
          for (int k = 1; k < MAX_SKEW-1; k++) hist[i][k] <= hist[i][k-1];
        end
      end
    end
  end

  // Measurement and lock control
  state_t              state;
  logic [DW:0]         cnt;
  logic [DW:0]         cnt_next;
  logic [LANES-1:0]    recorded;
  logic [LANES-1:0]    new_rec;
  logic [LANES-1:0]    rec_next;
  logic [DW-1:0]       arrival  [LANES];
  logic [DW-1:0]       arr_next [LANES];
  logic [DW-1:0]       max_arr;
  logic [DW*LANES-1:0] delay_calc;
  logic [LANES-1:0]    en_com_out;
  logic                timeout;
  logic                all_rec;
  logic                misalign;
  // The output word registered on the locking edge still used the old
  // delays, so it is not meaningful for the alignment check.
  logic                fresh;

  always_comb begin
    cnt_next = cnt + 1'b1;
    // An arrival of MAX_SKEW words cannot be compensated, so the timeout
    // wins even if the missing COM shows up in that very word.
    timeout  = (cnt_next == (DW+1)'(MAX_SKEW));
    new_rec  = com_in & lane_en & ~recorded;
    rec_next = recorded | new_rec;
    all_rec  = (|lane_en) && ((rec_next & lane_en) == lane_en);
    max_arr  = '0;
    for (int i = 0; i < LANES; i++) begin
      arr_next[i] = new_rec[i] ? cnt_next[DW-1:0] : arrival[i];
      if (lane_en[i] && (arr_next[i] > max_arr)) max_arr = arr_next[i];
    end
    delay_calc = '0;
    for (int i = 0; i < LANES; i++) begin
      if (lane_en[i]) delay_calc[i*DW +: DW] = max_arr - arr_next[i];
    end
    en_com_out = com_out & lane_en;
    misalign   = (|en_com_out) && (en_com_out != lane_en);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= HUNT;
      cnt        <= '0;
      recorded   <= '0;
      locked     <= 1'b0;
      skew_err   <= 1'b0;
      fresh      <= 1'b0;
      lane_delay <= '0;
      for (int i = 0; i < LANES; i++) arrival[i] <= '0;
    end else begin
      skew_err <= 1'b0;
      if (relock) begin
        state    <= HUNT;
        recorded <= '0;
        locked   <= 1'b0;
      end else begin
        case (state)
          HUNT: begin
            if (rx_valid && |(com_in & lane_en)) begin
              state    <= MEASURE;
              cnt      <= '0;
              recorded <= com_in & lane_en;
              for (int i = 0; i < LANES; i++) arrival[i] <= '0;
            end
          end
          MEASURE: begin
            if (rx_valid) begin
              if (timeout) begin
                skew_err <= 1'b1;
                state    <= HUNT;
                recorded <= '0;
              end else begin
                cnt      <= cnt_next;
                recorded <= rec_next;
                for (int i = 0; i < LANES; i++) arrival[i] <= arr_next[i];
                if (all_rec) begin
                  lane_delay <= delay_calc;
                  state      <= LOCKED;
                  locked     <= 1'b1;
                  fresh      <= 1'b1;
                end
              end
            end
          end
          LOCKED: begin
            if (out_valid) begin
              if (fresh) begin
                fresh <= 1'b0;
              end else if (misalign) begin
                skew_err <= 1'b1;
                locked   <= 1'b0;
                state    <= HUNT;
                recorded <= '0;
              end
            end
          end
          default: begin
            state  <= HUNT;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pcie_lane_deskew.sv
// Testbench for pcie_lane_deskew (LANES=4, MAX_SKEW=8).
// Each lane carries an ordered-set stream with period 16 words: COM in
// phase 0, random non-COM words otherwise. The skew of a lane is the
// number of words its COM trails the earliest lane. The expected delay is
// max(skew) - skew for enabled lanes. The expected output word is read from
// a per-lane history of every word driven, indexed by that delay.
module tb_pcie_lane_deskew;
  localparam int LANES = 4;
  localparam int MAX_SKEW = 8;
  localparam int DW = $clog2(MAX_SKEW);
  localparam int PERIOD = 16;

  logic                clk = 1'b0;
  logic                rst;
  logic                rx_valid;
  logic [16*LANES-1:0] rx_data;
  logic [2*LANES-1:0]  rx_charisk;
  logic [2*LANES-1:0]  rx_err;
  logic [LANES-1:0]    lane_en;
  logic                relock;
  logic [16*LANES-1:0] out_data;
  logic [2*LANES-1:0]  out_charisk;
  logic [2*LANES-1:0]  out_err;
  logic                out_valid;
  logic                locked;
  logic                skew_err;
  logic [DW*LANES-1:0] lane_delay;

  pcie_lane_deskew #(.LANES(LANES), .MAX_SKEW(MAX_SKEW)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_charisk(rx_charisk), .rx_err(rx_err), .lane_en(lane_en),
    .relock(relock), .out_data(out_data), .out_charisk(out_charisk),
    .out_err(out_err), .out_valid(out_valid), .locked(locked),
    .skew_err(skew_err), .lane_delay(lane_delay)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int err_pulses = 0;

  // Reference model state
  logic [19:0] hist_m [LANES][PERIOD];
  int ph [LANES];
  int exp_d [LANES];
  int sk [LANES];
  int slip_lane = -1;
  bit chk_en = 1'b0;

  always @(negedge clk) if (skew_err === 1'b1) err_pulses++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW*LANES-1:0] pack_d();
    logic [DW*LANES-1:0] r;
    r = '0;
    for (int i = 0; i < LANES; i++) r[i*DW +: DW] = DW'(exp_d[i]);
    return r;
  endfunction

  // One clock: drive a word (or junk when not valid), then check.
  task automatic step(input bit v);
    logic [19:0] w;
    logic [19:0] nw [LANES];
    rx_valid = v;
    for (int i = 0; i < LANES; i++) begin
      if (!v)
        w = 20'($urandom);
      else if (ph[i] == 0 && slip_lane != i)
        w = {2'($urandom), 1'($urandom), 1'b1, 8'($urandom), 8'hBC};
      else
        w = {(($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00), 1'($urandom), 1'b0, 16'($urandom)};
      nw[i] = w;
      rx_data[16*i +: 16]  = w[15:0];
      rx_charisk[2*i +: 2] = w[17:16];
      rx_err[2*i +: 2]     = w[19:18];
    end
    @(posedge clk);
    #1;
    if (v) begin
      for (int i = 0; i < LANES; i++) begin
        for (int k = PERIOD-1; k > 0; k--) hist_m[i][k] = hist_m[i][k-1];
        hist_m[i][0] = nw[i];
        if (slip_lane == i) slip_lane = -1;
        else ph[i] = (ph[i] + 1) % PERIOD;
      end
    end
    chk("out_valid", out_valid, v);
    if (chk_en) begin
      for (int i = 0; i < LANES; i++)
        chk($sformatf("lane%0d_word", i),
            {out_err[2*i +: 2], out_charisk[2*i +: 2], out_data[16*i +: 16]},
            hist_m[i][exp_d[i]]);
    end
  endtask

  // n valid words with random bubbles in between
  task automatic stream(input int n);
    int done = 0;
    while (done < n) begin
      bit v = ($urandom_range(0, 3) != 0);
      step(v);
      if (v) done++;
    end
  endtask

  task automatic relock_pulse();
    relock = 1'b1;
    step(1'b0);
    relock = 1'b0;
    chk("locked_after_relock", locked, 1'b0);
  endtask

  task automatic reset_check(input string tag);
    rst = 1'b1;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, "_out_data"}, out_data, '0);
    chk({tag, "_out_charisk"}, out_charisk, '0);
    chk({tag, "_out_err"}, out_err, '0);
    chk({tag, "_out_valid"}, out_valid, 1'b0);
    chk({tag, "_locked"}, locked, 1'b0);
    chk({tag, "_skew_err"}, skew_err, 1'b0);
    chk({tag, "_lane_delay"}, lane_delay, '0);
    rst = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      exp_d[i] = 0;
      for (int k = 0; k < PERIOD; k++) hist_m[i][k] = '0;
    end
  endtask

  // Start streams with the given skews (min over enabled lanes is 0).
  task automatic start_streams(input logic [LANES-1:0] en);
    for (int i = 0; i < LANES; i++)
      ph[i] = en[i] ? (PERIOD - sk[i]) % PERIOD : $urandom_range(0, PERIOD-1);
  endtask

  task automatic lock_scen(input string tag, input logic [LANES-1:0] en);
    int mx = 0;
    int p0;
    lane_en = en;
    chk_en = 1'b0;
    relock_pulse();
    start_streams(en);
    for (int i = 0; i < LANES; i++) if (en[i] && sk[i] > mx) mx = sk[i];
    p0 = err_pulses;
    stream(mx + 3);
    for (int i = 0; i < LANES; i++) exp_d[i] = en[i] ? mx - sk[i] : 0;
    chk_en = 1'b1;
    stream(40);
    chk_en = 1'b0;
    chk({tag, "_locked"}, locked, 1'b1);
    chk({tag, "_lane_delay"}, lane_delay, pack_d());
    chk({tag, "_no_skew_err"}, err_pulses - p0, 0);
  endtask

  initial begin
    logic [DW*LANES-1:0] prev_d;
    int p0;
    int mn;
    rst = 1'b1; rx_valid = 1'b0; rx_data = '0; rx_charisk = '0; rx_err = '0;
    lane_en = '1; relock = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      ph[i] = 1; exp_d[i] = 0;
      for (int k = 0; k < PERIOD; k++) hist_m[i][k] = '0;
    end
    repeat (2) @(posedge clk);
    reset_check("reset");

    // Aligned lanes
    sk = '{0, 0, 0, 0};
    lock_scen("aligned", 4'b1111);

    // Skewed lanes: COM at words 3,0,2,1
    sk = '{3, 0, 2, 1};
    lock_scen("skewed", 4'b1111);

    // One-word slip on lane 1 while locked
    p0 = err_pulses;
    for (int n = 0; n < 64 && ph[1] != 8; n++) step(1'b1);
    slip_lane = 1;
    sk[1] = sk[1] + 1;
    stream(40);
    begin
      int mx = 0;
      for (int i = 0; i < LANES; i++) if (sk[i] > mx) mx = sk[i];
      for (int i = 0; i < LANES; i++) exp_d[i] = mx - sk[i];
    end
    chk("slip_one_pulse", err_pulses - p0, 1);
    chk("slip_relocked", locked, 1'b1);
    chk("slip_lane_delay", lane_delay, pack_d());
    chk_en = 1'b1;
    stream(20);
    chk_en = 1'b0;

    // Skew beyond range: lane 2 eight words late
    prev_d = pack_d();
    lane_en = 4'b1111;
    relock_pulse();
    sk = '{0, 0, 8, 0};
    start_streams(4'b1111);
    p0 = err_pulses;
    stream(12);
    chk("range_one_pulse", err_pulses - p0, 1);
    chk("range_not_locked", locked, 1'b0);
    chk("range_delay_kept", lane_delay, prev_d);
    sk = '{0, 0, 7, 0};
    lock_scen("range_retry", 4'b1111);

    // Lanes 1 and 3 disabled; their streams are unrelated
    sk = '{0, 6, 5, 2};
    lock_scen("en0101", 4'b0101);

    // No lanes enabled: never locks
    lane_en = 4'b0000;
    relock_pulse();
    p0 = err_pulses;
    stream(40);
    chk("en0_not_locked", locked, 1'b0);
    chk("en0_no_err", err_pulses - p0, 0);

    // Random skews
    for (int r = 0; r < 6; r++) begin
      mn = MAX_SKEW;
      for (int i = 0; i < LANES; i++) begin
        sk[i] = $urandom_range(0, MAX_SKEW-1);
        if (sk[i] < mn) mn = sk[i];
      end
      for (int i = 0; i < LANES; i++) sk[i] = sk[i] - mn;
      lock_scen($sformatf("rand%0d", r), 4'b1111);
    end

    // Reset while measuring
    lane_en = 4'b1111;
    relock_pulse();
    sk = '{0, 0, 6, 0};
    start_streams(4'b1111);
    stream(3);
    reset_check("rst_measure");

    // Reset while locked, then lock again from reset state
    sk = '{1, 4, 0, 2};
    lock_scen("pre_rst", 4'b1111);
    reset_check("rst_locked");
    sk = '{2, 0, 1, 3};
    lock_scen("post_rst", 4'b1111);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
